hrm_regbank: RTL

Parametrised successor to the HRM single-accumulator register: a bank of `NREG` signed registers, each `WIDTH` bits, sitting between the inbox, ALU and data-memory paths of the CPU datapath.
- Write port: loads from inbox, ALU, memory or another bank register, or performs in-place bump-up/bump-down/clear.
- Registered zero/negative flags track the last written value; a sticky overflow flag records bump overflow.
- Saturating or wrapping bump arithmetic is selected at elaboration time.

---
 rtl/hrm_regbank.sv | 101 ++++++++++
 1 files changed

// File: rtl/hrm_regbank.sv
// Bank of NREG signed registers with a load/move/bump/clear write port, registered zero/neg flags and a sticky bump-overflow flag.
// One-edge write latency; no handshake. The combinational read port R never sees the write in flight.
module hrm_regbank #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int SAT   = 1,
    localparam int IW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] iInbox,
    input  logic [WIDTH-1:0] iAlu,
    input  logic [WIDTH-1:0] iMem,
    input  logic [1:0]       muxR,
    input  logic [1:0]       op,
    input  logic             wR,
    input  logic [IW-1:0]    wIdx,
    input  logic [IW-1:0]    rdIdx,
    input  logic             clrOvf,
    output logic [WIDTH-1:0] R,
    output logic             oZero,
    output logic             oNeg,
    output logic             oOvf
);

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   bump_x;
    logic             bump_ovf;
    logic [WIDTH-1:0] bump_val;
    logic [WIDTH-1:0] wval;
    logic             ovf_set;

    assign R     = regs[rdIdx];
    assign cur   = regs[wIdx];
    assign cur_x = {cur[WIDTH-1], cur};

    always_comb begin
        src = iInbox;
        case (muxR)
            2'b00: src = iInbox;
            2'b01: src = iAlu;
            2'b10: src = iMem;
            2'b11: src = regs[rdIdx];
            default: src = iInbox;
        endcase
    end

    // Sign-extended one extra bit so overflow shows up as a mismatch of the top two bits.
    always_comb begin
        bump_x = cur_x;
        if (op == 2'b01)
            bump_x = cur_x + {{WIDTH{1'b0}}, 1'b1};
        else
            bump_x = cur_x - {{WIDTH{1'b0}}, 1'b1};
        bump_ovf = bump_x[WIDTH] ^ bump_x[WIDTH-1];
        bump_val = bump_x[WIDTH-1:0];
        if (SAT != 0 && bump_ovf)
            bump_val = (op == 2'b01) ? MAXV : MINV;
    end

    always_comb begin
        wval    = '0;
        ovf_set = 1'b0;
        case (op)
            2'b00: wval = src;
            2'b01, 2'b10: begin
                wval    = bump_val;
                ovf_set = wR & bump_ovf;
            end
            default: wval = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            oZero <= 1'b1;
            oNeg  <= 1'b0;
            oOvf  <= 1'b0;
        end else begin
            if (wR) begin
                regs[wIdx] <= wval;
                oZero      <= (wval == '0);
                oNeg       <= wval[WIDTH-1];
            end
            // A new overflow outranks a simultaneous clear.
            if (ovf_set)
                oOvf <= 1'b1;
            else if (clrOvf)
                oOvf <= 1'b0;
        end
    end

endmodule
